rtr_out_alloc: RTL
==================

# rtr_out_alloc

Per-output-port allocator for the 5-port, 2-VC mesh router. One instance sits in front of each output port (local, N, E, S, W). Each cycle it decides which input port drives that output's crossbar leg. It also owns each downstream virtual channel for the full duration of a packet. Switch allocation is round-robin, and VC ownership runs from head flit to tail flit.

## Interface
- NPORT, 5, number of requesting input ports; fixed at 5.
- NVC, 2, virtual channels per link; fixed at 2, so a VC id is 1 bit.
- PTRW, 3, width of the round-robin pointer.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NPORT  input port p has a flit routed to this output.
- req_vc  in  NPORT  VC requested by port p: bit p, 0 = VC0, 1 = VC1.
- req_tail  in  NPORT  flit at port p is a tail flit. A single-flit packet asserts tail together with its first request.
- dn_rdy  in  NVC  downstream VC v can accept a flit this cycle (derived from IACK).
- dn_lck  in  NVC  downstream VC v is locked by its far side; no new packet may claim it (ILCK).
- gnt  out  NPORT  one-hot switch grant, combinational.
- gnt_vld  out  1  |gnt.
- gnt_vc  out  1  VC of the granted flit; drives OVCH. 0 when gnt_vld = 0.
- vc_busy  out  NVC  VC v currently owned; registered; drives OLCK.
- vc_owner0, vc_owner1  out  PTRW  owning port of each VC; 0 when idle.

## Operation
- Each VC has a 2-state FSM: IDLE and BUSY(owner p).
- Port p is eligible when all of the following hold:
  - req[p] = 1.
  - Let v = req_vc[p]. dn_rdy[v] = 1.
  - Either VC v is BUSY with owner p, or VC v is IDLE and dn_lck[v] = 0.
- A port requesting a VC owned by another port is not eligible.
- A locked VC blocks new claims only. It never blocks the current owner.
- Arbitration:
  - Round-robin over eligible ports. Search order is ptr, ptr+1, …, wrapping 4→0.
  - The first eligible port wins. At most one grant per cycle.
  - gnt, gnt_vld and gnt_vc are purely combinational from inputs plus registered state. There are no other combinational paths.
- Pointer update:
  - On a grant to port p: ptr <= (p+1) mod 5. Port 4 wraps to 0; no 3-bit overflow to 5–7 is ever stored.
  - With no grant, ptr holds.
- VC FSM transitions on a grant to port p for VC v:
  - IDLE with req_tail = 0 → BUSY(p).
  - IDLE with req_tail = 1 → stays IDLE (single-flit packet).
  - BUSY(p) with req_tail = 1 → IDLE.
  - BUSY(p) with req_tail = 0 → stays BUSY.
- Owner stall:
  - If the owner drops req, or dn_rdy[v] = 0, mid-packet, the VC stays BUSY indefinitely.
  - The allocator has no timeout.
- The two VCs are independent. VC0 may be BUSY(1) while VC1 is BUSY(3). Only one of them receives a flit per cycle.
- Same-cycle claims: two ports requesting the same IDLE VC → the round-robin winner claims it and the loser is not granted. The loser is ineligible next cycle if the winner became owner.
- Reset:
  - ptr = 0.
  - Both VCs IDLE.
  - vc_busy = 2'b00, vc_owner0 = vc_owner1 = 0.
  - Combinational outputs follow from this state.
- Reset mid-packet aborts ownership immediately. Flushing upstream state is the router's job.

## Timing
- Grant latency 0: gnt is valid in the same cycle as req/dn_rdy.
- vc_busy/vc_owner reflect a claim or release one cycle after the granting edge.
- Back-to-back grants to the same owner on consecutive cycles are allowed. This gives full throughput of 1 flit/cycle.
- After a tail releases a VC at edge N, another port may claim it in cycle N+1. The released VC has no dead cycle.
- Fairness: every persistently eligible port is granted within 5 grant cycles.

## Test plan
- Reset, then req=5'b00001, req_vc=0, req_tail=0, dn_rdy=2'b11:
  - Same cycle: gnt=5'b00001, gnt_vc=0.
  - Next cycle: vc_busy=2'b01, vc_owner0=0, ptr=1.
- Port 2 owns VC0 and port 4 requests VC0 → port 4 is never granted while port 2 streams.
  - On port 2's tail grant, vc_busy[0] drops the next cycle.
  - Port 4 is granted in that same next cycle.
- All 5 ports request, each alternating VCs, every flit a tail, dn_rdy=11 → grants cycle 0,1,2,3,4,0 and ptr wraps 4→0.
- dn_lck=2'b10 with VC1 idle: port 3 requests VC1 → no grant. Port 1 (current VC1 owner set up beforehand) continues to be granted despite dn_lck[1]=1.
- Single-flit packet with req_tail=1 on its first request → granted; vc_busy stays 00.
- Owner dn_rdy[0]=0 for 10 cycles → no grants on VC0 and vc_busy[0] stays 1.
  - VC1 traffic from another port is granted meanwhile.
  - rst asserted mid-packet → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/rtr_out_alloc.sv
// rtr_out_alloc: round-robin switch allocator with per-VC packet ownership for one output port
module rtr_out_alloc #(
    parameter int NPORT = 5,
    parameter int NVC   = 2,
    parameter int PTRW  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NPORT-1:0] req_i,
    input  logic [NPORT-1:0] req_vc_i,
    input  logic [NPORT-1:0] req_tail_i,
    input  logic [NVC-1:0]   dn_rdy_i,
    input  logic [NVC-1:0]   dn_lck_i,
    output logic [NPORT-1:0] gnt_o,
    output logic             gnt_vld_o,
    output logic             gnt_vc_o,
    output logic [NVC-1:0]   vc_busy_o,
    output logic [PTRW-1:0]  vc_owner0_o,
    output logic [PTRW-1:0]  vc_owner1_o
);

    localparam logic IDLE = 1'b0;
    localparam logic BUSY = 1'b1;

    logic [PTRW-1:0]  ptr_q, ptr_d;
    logic [NVC-1:0]   busy_q, busy_d;
    logic [PTRW-1:0]  own0_q, own0_d, own1_q, own1_d;
    logic [NPORT-1:0] elig;
    logic             found, gvc, gtail;
    logic [PTRW-1:0]  gidx;

    // A port may proceed if its VC has room and it either owns the VC or may claim an unlocked idle one
    always_comb begin
        elig = '0;
        for (int p = 0; p < NPORT; p++) begin
            logic            v;
            logic [PTRW-1:0] own;
            v = req_vc_i[p];
            own = v ? own1_q : own0_q;
            elig[p] = req_i[p] & dn_rdy_i[v] & ((busy_q[v] == BUSY) ? (own == PTRW'(p)) : ~dn_lck_i[v]);
        end
    end

    // First eligible port in search order ptr, ptr+1, ... wrapping at NPORT wins
    always_comb begin
        found = 1'b0;
        gidx = '0;
        for (int k = 0; k < NPORT; k++) begin
            logic [PTRW:0] s;
            s = {1'b0, ptr_q} + (PTRW+1)'(k);
            if (s >= (PTRW+1)'(NPORT)) s = s - (PTRW+1)'(NPORT);
            if (!found && elig[s[PTRW-1:0]]) begin
                found = 1'b1;
                gidx = s[PTRW-1:0];
            end
        end
    end

    assign gnt_o       = found ? NPORT'(1) << gidx : '0;
    assign gnt_vld_o   = found;
    assign gvc         = found & req_vc_i[gidx];
    assign gtail       = req_tail_i[gidx];
    assign gnt_vc_o    = gvc;
    assign vc_busy_o   = busy_q;
    assign vc_owner0_o = own0_q;
    assign vc_owner1_o = own1_q;

    // Advance pointer past the winner; a VC changes state only when a head claims or a tail releases it
    always_comb begin
        ptr_d = ptr_q;
        busy_d = busy_q;
        own0_d = own0_q;
        own1_d = own1_q;
        if (found) begin
            ptr_d = (gidx == PTRW'(NPORT-1)) ? '0 : gidx + 1'b1;
            if (busy_q[gvc] == gtail) begin
                busy_d[gvc] = gtail ? IDLE : BUSY;
                if (gvc) own1_d = gtail ? '0 : gidx;
                else own0_d = gtail ? '0 : gidx;
            end
        end
    end

    // State registers with synchronous reset that aborts any packet in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            busy_q <= '0;
            own0_q <= '0;
            own1_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            busy_q <= busy_d;
            own0_q <= own0_d;
            own1_q <= own1_d;
        end
    end

endmodule
